vga_apb_blitter: RTL and testbench

//  APB-programmed pixel/rectangle-fill engine for the VGA framebuffer; generalises the bus-side

---
 rtl/vga_apb_blitter_if.sv | 37 +++
 rtl/vga_apb_blitter.sv | 203 ++++++++++++++++++++
 tb/tb_vga_apb_blitter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_apb_blitter_if.sv
// vga_apb_blitter_if -- bus bundle for the blitter.
// Carries the APB slave port (paddr/pwdata/pwrite/psel/penable in,
// prdata/pready/pslverr out) and the framebuffer write-side port
// (fb_req/fb_we/fb_addr/fb_wdata out, fb_rdata/fb_ack in). Signal suffixes
// are from the blitter's point of view.
//   slave  : the blitter
//   master : APB master + framebuffer RAM (system side / testbench)
interface vga_apb_blitter_if;
  logic [31:0] apb_paddr_i;
  logic [31:0] apb_pwdata_i;
  logic        apb_pwrite_i;
  logic        apb_psel_i;
  logic        apb_penable_i;
  logic [31:0] apb_prdata_o;
  logic        apb_pready_o;
  logic        apb_pslverr_o;
  logic        fb_req_o;
  logic        fb_we_o;
  logic [31:0] fb_addr_o;
  logic [31:0] fb_wdata_o;
  logic [31:0] fb_rdata_i;
  logic        fb_ack_i;

  modport slave (
    input  apb_paddr_i, apb_pwdata_i, apb_pwrite_i, apb_psel_i, apb_penable_i,
    output apb_prdata_o, apb_pready_o, apb_pslverr_o,
    output fb_req_o, fb_we_o, fb_addr_o, fb_wdata_o,
    input  fb_rdata_i, fb_ack_i
  );

  modport master (
    output apb_paddr_i, apb_pwdata_i, apb_pwrite_i, apb_psel_i, apb_penable_i,
    input  apb_prdata_o, apb_pready_o, apb_pslverr_o,
    input  fb_req_o, fb_we_o, fb_addr_o, fb_wdata_o,
    output fb_rdata_i, fb_ack_i
  );
endinterface

// File: rtl/vga_apb_blitter.sv
// vga_apb_blitter -- APB-programmed pixel / rectangle fill engine.
// Walks a rectangle in raster order and read-modify-writes each visible pixel
// of BPP bits in a 32-bit-word framebuffer; off-screen pixels are skipped and
// flagged in STATUS.CLIP.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus           : vga_apb_blitter_if.slave (APB slave + framebuffer master)
//   irq_o         : STATUS.DONE & IRQEN (only when VGA_BLIT_IRQ_EN is defined)
// Registers: 0x00 CTRL (W: [0]START [1]MODE), 0x04 XY, 0x08 WH, 0x0C COLOR,
//   0x10 STATUS ([0]BUSY [1]CLIP [2]DONE W1C), 0x14 IRQEN (VGA_BLIT_IRQ_EN only).
// Build option: VGA_BLIT_IRQ_EN adds irq_o and the IRQEN register.
module vga_apb_blitter #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned BPP           = 8,
  parameter logic [31:0] FB_BASE       = 32'h0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  vga_apb_blitter_if.slave  bus
`ifdef VGA_BLIT_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8 || BPP == 16 || BPP == 32)) begin : g_bad_bpp
    $error("vga_apb_blitter: BPP must be 1, 2, 4, 8, 16 or 32");
  end

  localparam logic [31:0] LANE_MASK = 32'((64'd1 << BPP) - 64'd1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RD, S_WR, S_STEP, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      xy_q, wh_q;
  logic [BPP-1:0]   color_q;
  logic             busy_q, clip_q, done_q;
  logic [15:0]      ox_q;               // rectangle left edge, reloaded at each new row
  logic [16:0]      cx_q, cy_q;         // current pixel, 17 bits so x0+w never wraps
  logic [16:0]      ex_q, ey_q;         // exclusive end coordinates
  logic             zero_q;             // empty rectangle
  logic [31:0]      fb_addr_q, wdata_q;
  logic [4:0]       off_q;
`ifdef VGA_BLIT_IRQ_EN
  logic             irqen_q;
`endif

  // ---------------- APB decode ----------------
  logic [4:0]  apb_off;
  logic        apb_acc, addr_ok, apb_err, apb_wr, start;
  logic [31:0] rdata;
  logic [15:0] st_w, st_h;
  logic        unused_addr;

  assign apb_off     = bus.apb_paddr_i[4:0];
  assign unused_addr = ^bus.apb_paddr_i[31:5];
  assign apb_acc     = bus.apb_psel_i & bus.apb_penable_i;
`ifdef VGA_BLIT_IRQ_EN
  assign addr_ok = (bus.apb_paddr_i[1:0] == 2'b00) && (apb_off <= 5'h14);
`else
  assign addr_ok = (bus.apb_paddr_i[1:0] == 2'b00) && (apb_off <= 5'h10);
`endif
  // STATUS only accepts the W1C form; operand registers are frozen while busy.
  assign apb_err = apb_acc && (!addr_ok || (bus.apb_pwrite_i &&
                   ((apb_off == 5'h10 && !bus.apb_pwdata_i[2]) || (busy_q && apb_off <= 5'h0C))));
  assign apb_wr  = apb_acc && bus.apb_pwrite_i && !apb_err;
  assign start   = apb_wr && (apb_off == 5'h00) && bus.apb_pwdata_i[0];
  // Pixel mode is a 1x1 rectangle.
  assign st_w    = bus.apb_pwdata_i[1] ? wh_q[15:0]  : 16'd1;
  assign st_h    = bus.apb_pwdata_i[1] ? wh_q[31:16] : 16'd1;

  always_comb begin
    rdata = '0;
    if (apb_acc && !bus.apb_pwrite_i && addr_ok) begin
      case (apb_off)
        5'h04:   rdata = xy_q;
        5'h08:   rdata = wh_q;
        5'h0C:   rdata = 32'(color_q);
        5'h10:   rdata = {29'b0, done_q, clip_q, busy_q};
`ifdef VGA_BLIT_IRQ_EN
        5'h14:   rdata = {31'b0, irqen_q};
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign bus.apb_prdata_o  = rdata;
  assign bus.apb_pready_o  = apb_acc;
  assign bus.apb_pslverr_o = apb_err;

  // ---------------- pixel address / merge ----------------
  logic [31:0] pix_idx, pix_bit, pix_addr, pix_mask, color_sh, merged;
  logic        offscreen, x_last, y_last;

  assign pix_idx   = 32'(cy_q) * 32'(SCREEN_WIDTH) + 32'(cx_q);
  assign pix_bit   = pix_idx * BPP;
  assign pix_addr  = FB_BASE + {3'b000, pix_bit[31:5], 2'b00};
  assign pix_mask  = LANE_MASK << off_q;
  assign color_sh  = 32'(color_q) << off_q;
  assign merged    = (bus.fb_rdata_i & ~pix_mask) | (color_sh & pix_mask);
  assign offscreen = (cx_q >= 17'(SCREEN_WIDTH)) || (cy_q >= 17'(SCREEN_HEIGHT));
  assign x_last    = (cx_q + 17'd1) == ex_q;
  assign y_last    = (cy_q + 17'd1) == ey_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: begin
        if (zero_q)         state_d = S_FIN;
        else if (offscreen) state_d = S_STEP;
        else if (BPP == 32) state_d = S_WR;   // full-word pixel: no read needed
        else                state_d = S_RD;
      end
      S_RD:    if (bus.fb_ack_i) state_d = S_WR;
      S_WR:    if (bus.fb_ack_i) state_d = S_STEP;
      S_STEP:  state_d = (x_last && y_last) ? S_FIN : S_SETUP;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- registers / datapath ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      xy_q <= '0; wh_q <= '0; color_q <= '0;
      busy_q <= 1'b0; clip_q <= 1'b0; done_q <= 1'b0;
      ox_q <= '0; cx_q <= '0; cy_q <= '0; ex_q <= '0; ey_q <= '0; zero_q <= 1'b0;
      fb_addr_q <= '0; wdata_q <= '0; off_q <= '0;
`ifdef VGA_BLIT_IRQ_EN
      irqen_q <= 1'b0;
`endif
    end else begin
      if (apb_wr) begin
        case (apb_off)
          5'h04:   xy_q    <= bus.apb_pwdata_i;
          5'h08:   wh_q    <= bus.apb_pwdata_i;
          5'h0C:   color_q <= bus.apb_pwdata_i[BPP-1:0];
          5'h10:   done_q  <= 1'b0;
`ifdef VGA_BLIT_IRQ_EN
          5'h14:   irqen_q <= bus.apb_pwdata_i[0];
`endif
          default: ;
        endcase
      end
      if (start) begin
        busy_q <= 1'b1;
        clip_q <= 1'b0;
        done_q <= 1'b0;
        ox_q   <= xy_q[15:0];
        cx_q   <= {1'b0, xy_q[15:0]};
        cy_q   <= {1'b0, xy_q[31:16]};
        ex_q   <= {1'b0, xy_q[15:0]}  + {1'b0, st_w};
        ey_q   <= {1'b0, xy_q[31:16]} + {1'b0, st_h};
        zero_q <= (st_w == 16'd0) || (st_h == 16'd0);
      end
      case (state_q)
        S_SETUP: if (!zero_q) begin
          if (offscreen) clip_q <= 1'b1;
          else begin
            fb_addr_q <= pix_addr;
            off_q     <= pix_bit[4:0];
            if (BPP == 32) wdata_q <= 32'(color_q);
          end
        end
        S_RD:   if (bus.fb_ack_i) wdata_q <= merged;
        S_STEP: begin
          if (x_last) begin
            cx_q <= {1'b0, ox_q};
            cy_q <= cy_q + 17'd1;
          end else begin
            cx_q <= cx_q + 17'd1;
          end
        end
        // Placed after the W1C decode so a completing op's DONE wins.
        S_FIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // req is decoded from state so an async reset drops it immediately.
  assign bus.fb_req_o   = (state_q == S_RD) || (state_q == S_WR);
  assign bus.fb_we_o    = (state_q == S_WR);
  assign bus.fb_addr_o  = fb_addr_q;
  assign bus.fb_wdata_o = wdata_q;

`ifdef VGA_BLIT_IRQ_EN
  assign irq_o = done_q & irqen_q;
`endif

endmodule

// File: tb/tb_vga_apb_blitter.sv
// tb_vga_apb_blitter -- scoreboard bench for vga_apb_blitter (BPP=8).
// A reference model walks each requested rectangle with plain arithmetic and
// queues the framebuffer accesses it expects; a RAM responder pops and
// compares on every acked access. APB accesses queue their expected
// pslverr/prdata and a separate monitor compares during the access phase.
module tb_vga_apb_blitter;
  localparam int          W       = 640;
  localparam int          H       = 480;
  localparam int          BPP     = 8;
  localparam logic [31:0] FB_BASE = 32'h0;
`ifdef VGA_BLIT_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
  logic irq;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vga_apb_blitter_if bus();

  vga_apb_blitter #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BPP(BPP), .FB_BASE(FB_BASE)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
`ifdef VGA_BLIT_IRQ_EN
    ,
    .irq_o  (irq)
`endif
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } fb_t;
  typedef struct { string nm; logic chk; logic [31:0] data; logic err; } apb_t;

  fb_t         fb_q[$];
  apb_t        apb_q[$];
  logic [31:0] ram    [int unsigned];
  logic [31:0] shadow [int unsigned];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          hold_wr  = 1'b0;

  function automatic logic [31:0] mem_seed(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return mem_seed(a);
  endfunction
  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return mem_seed(a);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  // RAM responder + framebuffer scoreboard
  initial begin
    fb_t e;
    bus.fb_ack_i   = 1'b0;
    bus.fb_rdata_i = '0;
    forever begin
      @(negedge clk); #1;
      if (bus.fb_req_o && !(hold_wr && bus.fb_we_o) && ($urandom_range(0, 3) != 0)) begin
        bus.fb_ack_i   = 1'b1;
        bus.fb_rdata_i = bus.fb_we_o ? 32'h0 : ram_rd(bus.fb_addr_o);
        if (fb_q.size() == 0) begin
          n_checks++;
          $display("FAIL fb_extra: got access we=%0b addr=0x%08h, want none", bus.fb_we_o, bus.fb_addr_o);
        end else begin
          e = fb_q.pop_front();
          check("fb_we", {31'b0, bus.fb_we_o}, {31'b0, e.we});
          check("fb_addr", bus.fb_addr_o, e.addr);
          if (e.we) check("fb_wdata", bus.fb_wdata_o, e.data);
        end
        if (bus.fb_we_o) ram[bus.fb_addr_o] = bus.fb_wdata_o;
      end else begin
        bus.fb_ack_i = 1'b0;
      end
    end
  end

  // APB monitor
  initial begin
    apb_t e;
    forever begin
      @(negedge clk); #2;
      if (bus.apb_psel_i && bus.apb_penable_i) begin
        if (apb_q.size() == 0) begin
          n_checks++;
          $display("FAIL apb_extra: got unexpected access to 0x%08h, want none", bus.apb_paddr_i);
        end else begin
          e = apb_q.pop_front();
          check({e.nm, "_pready"}, {31'b0, bus.apb_pready_o}, 32'd1);
          check({e.nm, "_pslverr"}, {31'b0, bus.apb_pslverr_o}, {31'b0, e.err});
          if (e.chk) check({e.nm, "_prdata"}, bus.apb_prdata_o, e.data);
        end
      end
    end
  end

  task automatic apb(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic chk_rd, input logic [31:0] exp, input logic err, output logic [31:0] rd);
    apb_q.push_back('{nm, chk_rd, exp, err});
    @(negedge clk);
    bus.apb_psel_i = 1'b1; bus.apb_penable_i = 1'b0;
    bus.apb_pwrite_i = wr; bus.apb_paddr_i = a; bus.apb_pwdata_i = d;
    @(negedge clk);
    bus.apb_penable_i = 1'b1;
    #3 rd = bus.apb_prdata_o;
    @(negedge clk);
    bus.apb_psel_i = 1'b0; bus.apb_penable_i = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d, input logic err);
    logic [31:0] dummy;
    apb(nm, 1'b1, a, d, 1'b0, 32'h0, err, dummy);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp, input logic err);
    logic [31:0] dummy;
    apb(nm, 1'b0, a, 32'h0, ~err, exp, err, dummy);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int i;
    s = 32'h1;
    for (i = 0; i < 400 && s[0]; i++) apb("poll", 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, s);
    if (s[0]) begin
      n_checks++;
      $display("FAIL busy_timeout: got STATUS 0x%08h after %0d polls, want BUSY=0", s, i);
    end
  endtask

  // Reference model: visit every pixel of the rectangle in raster order.
  task automatic model_op(input int x0, input int y0, input int w_in, input int h_in,
                          input bit mode, input logic [31:0] color, output bit clip);
    int w, h, off;
    longint bitpos;
    logic [31:0] a, old, nw;
    logic [63:0] mask;
    w = mode ? w_in : 1;
    h = mode ? h_in : 1;
    clip = 1'b0;
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) begin
        if (x >= W || y >= H) clip = 1'b1;
        else begin
          bitpos = (longint'(y) * W + x) * BPP;
          a      = FB_BASE + 32'((bitpos / 32) * 4);
          off    = int'(bitpos % 32);
          mask   = ((64'd1 << BPP) - 64'd1) << off;
          old    = sh_rd(a);
          nw     = (old & ~mask[31:0]) | ((color << off) & mask[31:0]);
          if (BPP < 32) fb_q.push_back('{1'b0, a, 32'h0});
          fb_q.push_back('{1'b1, a, nw});
          shadow[a] = nw;
        end
      end
  endtask

  task automatic run_op(input int x, input int y, input int w, input int h,
                        input bit mode, input logic [31:0] color_in, input bit poke);
    bit clip;
    logic [31:0] color;
    color = color_in & 32'((64'd1 << BPP) - 64'd1);
    model_op(x, y, w, h, mode, color, clip);
    wr("xy", 32'h04, {y[15:0], x[15:0]}, 1'b0);
    wr("wh", 32'h08, {h[15:0], w[15:0]}, 1'b0);
    wr("color", 32'h0C, color, 1'b0);
    wr("start", 32'h00, {30'b0, mode, 1'b1}, 1'b0);
    if (poke) begin
      wr("xy_busy", 32'h04, 32'hDEADBEEF, 1'b1);
      rd("xy_kept", 32'h04, {y[15:0], x[15:0]}, 1'b0);
    end
    wait_idle();
    rd("status_done", 32'h10, {29'b0, 1'b1, clip, 1'b0}, 1'b0);
    check("fb_pending", fb_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, w, h;
    logic [31:0] a;
    bus.apb_psel_i = 1'b0; bus.apb_penable_i = 1'b0; bus.apb_pwrite_i = 1'b0;
    bus.apb_paddr_i = '0; bus.apb_pwdata_i = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fb_req", {31'b0, bus.fb_req_o}, 32'd0);
    check("rst_fb_addr", bus.fb_addr_o, 32'd0);
    rstn = 1'b1;

    // reset values
    rd("rst_ctrl", 32'h00, 32'h0, 1'b0);
    rd("rst_xy", 32'h04, 32'h0, 1'b0);
    rd("rst_wh", 32'h08, 32'h0, 1'b0);
    rd("rst_color", 32'h0C, 32'h0, 1'b0);
    rd("rst_status", 32'h10, 32'h0, 1'b0);

    // address / access errors
    rd("misaligned", 32'h02, 32'h0, 1'b1);
    rd("off_14", 32'h14, 32'h0, !HAS_IRQ);
    rd("off_1c", 32'h1C, 32'h0, 1'b1);
    wr("status_w0", 32'h10, 32'h0, 1'b1);
    wr("status_w3", 32'h10, 32'h3, 1'b1);
    rd("status_kept", 32'h10, 32'h0, 1'b0);

    // single pixel read-modify-write into a known word
    ram[0] = 32'h11223344;
    shadow[0] = 32'h11223344;
    run_op(1, 0, 7, 9, 1'b0, 32'hAB, 1'b0);
    check("pix_word0", ram[0], 32'h1122AB44);

    // bottom-right corner rectangle, partly clipped, with a write while busy
    run_op(638, 479, 4, 2, 1'b1, 32'h3C, 1'b1);

    // W1C of DONE keeps CLIP
    wr("w1c_done", 32'h10, 32'h4, 1'b0);
    rd("status_w1c", 32'h10, 32'h2, 1'b0);

    // empty rectangle and coordinate no-wrap
    run_op(10, 10, 0, 3, 1'b1, 32'h11, 1'b0);
    run_op(32'hFFFF, 0, 2, 1, 1'b1, 32'h22, 1'b0);

`ifdef VGA_BLIT_IRQ_EN
    wr("irqen", 32'h14, 32'h1, 1'b0);
    run_op(3, 3, 1, 1, 1'b0, 32'h5A, 1'b0);
    check("irq_high", {31'b0, irq}, 32'd1);
    wr("irq_w1c", 32'h10, 32'h4, 1'b0);
    check("irq_low", {31'b0, irq}, 32'd0);
`endif

    // randomized rectangles around the screen and its edges
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom_range(0, W - 1);  y = $urandom_range(0, H - 1);  end
        1: begin x = $urandom_range(W - 4, W + 2); y = $urandom_range(0, H - 1); end
        2: begin x = $urandom_range(0, W - 1);  y = $urandom_range(H - 3, H + 1); end
        default: begin x = $urandom_range(0, 8); y = $urandom_range(0, 4); end
      endcase
      w = $urandom_range(0, 4);
      h = $urandom_range(0, 3);
      run_op(x, y, w, h, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    // async reset while a write is outstanding
    hold_wr = 1'b1;
    a = FB_BASE + 32'(((3 * W + 5) * BPP / 32) * 4);
    fb_q.push_back('{1'b0, a, 32'h0});
    wr("rst_xy_set", 32'h04, {16'd3, 16'd5}, 1'b0);
    wr("rst_color_set", 32'h0C, 32'h5A, 1'b0);
    wr("rst_start", 32'h00, 32'h1, 1'b0);
    for (int i = 0; i < 100 && !(bus.fb_req_o && bus.fb_we_o); i++) @(negedge clk);
    check("wr_reached", {31'b0, bus.fb_req_o && bus.fb_we_o}, 32'd1);
    #3 rstn = 1'b0;
    #1 check("req_on_reset", {31'b0, bus.fb_req_o}, 32'd0);
    check("we_on_reset", {31'b0, bus.fb_we_o}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    hold_wr = 1'b0;
    rd("post_rst_status", 32'h10, 32'h0, 1'b0);
    rd("post_rst_xy", 32'h04, 32'h0, 1'b0);
    check("post_rst_fb_pending", fb_q.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("no_access_after_rst", fb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
